// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N-to-1 stream multiplexer.
//   clog2 / sel_width : derive the channel-index width from a channel count
//   MODE_FIXED/MODE_RR: encodings of the mode_rr input
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width, never narrower than one bit (a single channel still needs a sel port).
  function automatic int sel_width(input int num_in);
    return (clog2(num_in) < 1) ? 1 : clog2(num_in);
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// rr_grant_picker: combinational round-robin pick.
//   req         : per-channel request (in_valid)
//   ptr         : channel with highest priority this cycle
//   grant       : first requesting channel scanning ptr, ptr+1, ... mod NUM_IN
//   grant_valid : high when any channel requests
module rr_grant_picker
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    // Scan from the farthest offset back to ptr so the nearest requester is
    // the last one written and therefore wins.
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n_by_one_stream_mux.sv
// n_by_one_stream_mux: registered N-to-1 stream mux with valid/ready on
// every port; fixed-select or round-robin arbitration.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_valid    : flattened channel data (ch i at [i*WIDTH +: WIDTH]) / valids
//   in_ready            : per-channel ready, at most one bit high
//   mode_rr, sel        : 0 = use sel, 1 = round-robin among valid inputs
//   out_data/out_valid  : registered selected word
//   out_ready           : consumer accept
//   out_src             : channel index that supplied out_data
// Handshake: a word moves on any rising edge where valid and ready are both
// high on that interface; valid never depends on ready of the same port.
// Optional macro N_BY_ONE_MUX_SKID_EN adds a one-entry skid register behind
// out_data so in_ready comes from a flop instead of out_ready.
module n_by_one_stream_mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  // Derived; leave at default.
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode_rr,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_grant_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             stage_can_accept;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;
  logic             grant_in_valid;
  logic [SEL_W-1:0] rr_ptr_next;

  rr_grant_picker #(
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_picker (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .grant      (rr_grant),
    .grant_valid(rr_grant_valid)
  );

  always_comb begin
    if (mode_rr == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_grant_valid;
    end else begin
      grant    = sel;
      grant_ok = (int'(sel) < NUM_IN);
    end
  end

  // Loop-based select keeps an out-of-range sel from indexing past in_data.
  always_comb begin
    grant_data     = '0;
    grant_in_valid = 1'b0;
    in_ready       = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_ok && grant == SEL_W'(i)) begin
        grant_data     = in_data[i*WIDTH +: WIDTH];
        grant_in_valid = in_valid[i];
        in_ready[i]    = stage_can_accept && !reset;
      end
    end
  end

  assign transfer    = grant_ok && grant_in_valid && stage_can_accept && !reset;
  assign rr_ptr_next = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= rr_ptr_next;
    end
  end

`ifdef N_BY_ONE_MUX_SKID_EN
  // The skid slot only fills while out_data holds a stalled word, so an empty
  // output register always implies an empty skid.
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_src;

  assign stage_can_accept = !skid_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_src  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_full) begin
        // Older word first; no transfer can happen while skid is full.
        out_valid <= 1'b1;
        out_data  <= skid_data;
        out_src   <= skid_src;
        skid_full <= 1'b0;
      end else if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (transfer) begin
      skid_full <= 1'b1;
      skid_data <= grant_data;
      skid_src  <= grant;
    end
  end
`else
  assign stage_can_accept = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant;
    end else if (out_ready) begin
      // Drain with no refill: data stays, only valid drops.
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_n_by_one_stream_mux.sv
module tb_n_by_one_stream_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- 4-channel DUT ----------------
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode_rr;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;

  n_by_one_stream_mux #(.WIDTH(8), .NUM_IN(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode_rr  (mode_rr),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src  (out_src)
  );

  // ---------------- 3-channel DUT (out-of-range sel) ----------------
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_src3;

  n_by_one_stream_mux #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data3),
    .in_valid (in_valid3),
    .in_ready (in_ready3),
    .mode_rr  (1'b0),
    .sel      (sel3),
    .out_data (out_data3),
    .out_valid(out_valid3),
    .out_ready(out_ready3),
    .out_src  (out_src3)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are read then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    in_data[ch*8 +: 8] = d;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = '0;
    mode_rr    = 1'b0;
    sel        = 2'd2;
    out_ready  = 1'b1;
    in_data3   = '0;
    in_valid3  = '0;
    sel3       = 2'd0;
    out_ready3 = 1'b1;
    tick();
    tick();

    // Reset state and forced-low ready.
    in_valid = 4'b0100;
    settle();
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_src", out_src, 2'd0);
    tick();
    reset = 1'b0;

    // Fixed select, ch2 = A5.
    set_ch(2, 8'hA5);
    settle();
    chk("fix_in_ready", in_ready, 4'b0100);
    tick();
    chk("fix_out_valid", out_valid, 1'b1);
    chk("fix_out_data", out_data, 8'hA5);
    chk("fix_out_src", out_src, 2'd2);

`ifndef N_BY_ONE_MUX_SKID_EN
    // Back-pressure: held word must not move.
    out_ready = 1'b0;
    set_ch(2, 8'h3C);
    settle();
    chk("bp_in_ready", in_ready, 4'b0000);
    tick();
    chk("bp_hold_data", out_data, 8'hA5);
    chk("bp_hold_src", out_src, 2'd2);
    sel = 2'd1;
    mode_rr = 1'b1;
    tick();
    chk("bp_hold_data2", out_data, 8'hA5);
    chk("bp_hold_valid", out_valid, 1'b1);
    mode_rr = 1'b0;
    sel = 2'd2;
    out_ready = 1'b1;
    settle();
    chk("bp_release_ready", in_ready, 4'b0100);
    tick();
    chk("bp_out_3c", out_data, 8'h3C);
    set_ch(2, 8'h5A);
    tick();
    chk("tput_5a", out_data, 8'h5A);
    set_ch(2, 8'h77);
    tick();
    chk("tput_77", out_data, 8'h77);
    chk("tput_valid", out_valid, 1'b1);

    // Drain only.
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data_kept", out_data, 8'h77);
`endif

    // Reset to bring rr_ptr back to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Round-robin, all valid: 0,1,2,3,0.
    mode_rr  = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 8'h10 + 8'(i));
    settle();
    chk("rr_first_ready", in_ready, 4'b0001);
    tick();
    chk("rr_src0", out_src, 2'd0);
    chk("rr_data0", out_data, 8'h10);
    tick();
    chk("rr_src1", out_src, 2'd1);
    tick();
    chk("rr_src2", out_src, 2'd2);
    tick();
    chk("rr_src3", out_src, 2'd3);
    chk("rr_data3", out_data, 8'h13);
    tick();
    chk("rr_src0_again", out_src, 2'd0);

    // rr_ptr = 1 now; only ch0 and ch3 valid -> 3 then wrap to 0.
    in_valid = 4'b1001;
    settle();
    chk("wrap_ready3", in_ready, 4'b1000);
    tick();
    chk("wrap_src3", out_src, 2'd3);
    chk("wrap_data3", out_data, 8'h13);
    chk("wrap_ready0", in_ready, 4'b0001);
    tick();
    chk("wrap_src0", out_src, 2'd0);
    chk("wrap_data0", out_data, 8'h10);

    // No valid input in round-robin: no grant.
    in_valid = 4'b0000;
    settle();
    chk("rr_idle_ready", in_ready, 4'b0000);
    tick();
    chk("rr_idle_valid", out_valid, 1'b0);

    // Reset while a word is held overrides a simultaneous transfer.
    mode_rr   = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    chk("rstmid_pre_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    reset     = 1'b1;
    settle();
    chk("rstmid_ready", in_ready, 4'b0000);
    tick();
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_src", out_src, 2'd0);
    reset    = 1'b0;
    mode_rr  = 1'b1;
    in_valid = 4'b1111;
    settle();
    chk("rstmid_ptr0", in_ready, 4'b0001);
    in_valid = 4'b0000;

    // NUM_IN = 3: load ch1, then sel = 3 is out of range.
    in_data3  = 24'h33_22_11;
    in_valid3 = 3'b111;
    sel3      = 2'd1;
    settle();
    chk("n3_ready1", in_ready3, 3'b010);
    tick();
    chk("n3_data", out_data3, 8'h22);
    chk("n3_src", out_src3, 2'd1);
    sel3 = 2'd3;
    settle();
    chk("n3_oor_ready", in_ready3, 3'b000);
    tick();
    chk("n3_oor_drain", out_valid3, 1'b0);

`ifdef N_BY_ONE_MUX_SKID_EN
    // Two words accepted during a stall, then delivered in order.
    mode_rr   = 1'b0;
    sel       = 2'd1;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_ch(1, 8'h11);
    settle();
    chk("skid_ready_a", in_ready, 4'b0010);
    tick();
    chk("skid_out_11", out_data, 8'h11);
    set_ch(1, 8'h22);
    settle();
    chk("skid_ready_b", in_ready, 4'b0010);
    tick();
    chk("skid_full_ready", in_ready, 4'b0000);
    chk("skid_hold_11", out_data, 8'h11);
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("skid_out_22", out_data, 8'h22);
    chk("skid_out_valid", out_valid, 1'b1);
    tick();
    chk("skid_empty", out_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
